neuron_serial_mac: RTL and testbench
====================================

Name: neuron_serial_mac

Overview:
Parametrised, time-multiplexed single neuron. It computes a bias plus the sum of INPUT_COUNT signed input×weight products, using one multiply-accumulate per cycle, then applies a run-time-selectable activation. It is the successor to the fixed 8-bit serial neuron and is used as the per-neuron compute element inside layer arrays. Compared with that block it adds configurable data and accumulator widths, a bias term, an output scaling shift, saturation, an overflow flag and an explicit busy/ready handshake.

Parameters:
DATA_W, 8, width of each input, weight and output (two's complement)
ACC_W, 32, accumulator width (signed); must satisfy ACC_W >= 2*DATA_W
INPUT_COUNT, 8, number of input/weight pairs per operation (>= 1)
SHIFT, 0, arithmetic right shift applied to the accumulator before activation (0 <= SHIFT < ACC_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start_signal  input  1  operation request, sampled on clk
inputs  input  INPUT_COUNT*DATA_W  input vector; element i at bits [i*DATA_W +: DATA_W]
weights  input  INPUT_COUNT*DATA_W  weight vector, same packing as inputs
bias  input  ACC_W  signed bias, added once per operation
act_mode  input  2  activation: 00 identity, 01 ReLU, 10 step, 11 reserved (treated as identity)
out  output  DATA_W  signed activated result
ready_signal  output  1  result valid; level signal
busy  output  1  operation in progress
overflow  output  1  sticky accumulator overflow flag for the current or last operation

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; acc, index, out, ready_signal, busy and overflow all cleared to 0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, MAC, ACT, DONE.
- IDLE or DONE with start_signal=1 at edge k:
  - Capture inputs, weights, bias and act_mode into internal registers; later changes on these ports are ignored.
  - acc <= bias; index <= 0; overflow <= 0; ready_signal <= 0; busy <= 1; go to MAC.
- MAC:
  - Each edge: acc <= acc + sext(x[index] * w[index]). The product is a signed 2*DATA_W value, sign-extended to ACC_W.
  - index increments each edge; after the edge that consumes index INPUT_COUNT-1 (edge k+INPUT_COUNT), go to ACT.
  - Overflow: any add whose operands share a sign and whose result sign differs sets overflow=1. The flag is sticky until the next accepted start. The accumulator wraps; it is not clamped.
- ACT (edge k+INPUT_COUNT+1):
  - s = acc >>> SHIFT.
  - identity: out = s clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU: out = 0 if s < 0, else s clamped to the maximum.
  - step: out = 2^(DATA_W-1)-1 if s > 0, else 0.
  - ready_signal <= 1; busy <= 0; go to DONE.
- Latency: ready_signal rises INPUT_COUNT+1 cycles after the start-capturing edge. Throughput is one result per INPUT_COUNT+2 cycles with back-to-back starts.
- DONE:
  - out, ready_signal and overflow are held indefinitely.
  - start_signal=1 behaves as in IDLE; ready_signal falls on that same edge.
- start_signal while busy=1 (MAC or ACT) is ignored; no queuing.
- busy and ready_signal are never both 1.
- Index counter width is $clog2(INPUT_COUNT), minimum 1 bit.
- INPUT_COUNT=1 is legal: one MAC cycle, then ACT.

Test Plan:
- Defaults, all inputs=1, weights=2, bias=0, identity -> out=16 (0x10); ready_signal at edge k+9; busy high for edges k..k+8; overflow=0.
- Inputs=100, weights=100, bias=0, identity -> acc=80000, out=127 (saturated), overflow=0. Same stimulus with SHIFT=10 -> out=78.
- Inputs=-3 (0xFD), weights=5, bias=10 -> acc=-110. identity gives out=0x92; ReLU gives out=0; step gives out=0. Bias=200 with step -> out=127.
- Pulse start during MAC at cycle k+3 -> ignored; result and timing unchanged. New start in DONE with different vectors -> ready_signal drops on that edge, and the new result arrives INPUT_COUNT+1 cycles later.
- Assert rst at cycle k+4 of an operation -> out, ready_signal, busy and overflow go to 0 immediately, without a clock. After release, a fresh start yields the correct result.
- ACC_W=16, inputs=-128, weights=-128, bias=0 -> the second add exceeds 32767, so overflow=1 and stays 1 through DONE. A subsequent start with small values clears it to 0.

Source files
------------

// File: rtl/neuron_serial_mac.sv
// Time-multiplexed neuron: bias plus serial signed MAC,
// followed by shift, saturation and a selectable activation.
module neuron_serial_mac #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int INPUT_COUNT = 8,
  parameter int SHIFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_signal,
  input  logic [INPUT_COUNT*DATA_W-1:0] inputs,
  input  logic [INPUT_COUNT*DATA_W-1:0] weights,
  input  logic [ACC_W-1:0]              bias,
  input  logic [1:0]                    act_mode,
  output logic [DATA_W-1:0]             out,
  output logic                          ready_signal,
  output logic                          busy,
  output logic                          overflow
);

  localparam int IDX_W =
    (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam int VEC_W = INPUT_COUNT * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(INPUT_COUNT - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ACT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [VEC_W-1:0]        x_q, x_d;
  logic [VEC_W-1:0]        w_q, w_d;
  logic [1:0]              mode_q, mode_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]       out_q, out_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;

  logic signed [DATA_W-1:0]   x_cur;
  logic signed [DATA_W-1:0]   w_cur;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       add_ovf;
  logic signed [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]          sat;
  logic [DATA_W-1:0]          act_res;

  assign x_cur    = x_q[idx_q*DATA_W +: DATA_W];
  assign w_cur    = w_q[idx_q*DATA_W +: DATA_W];
  assign prod     = x_cur * w_cur;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;
  assign add_ovf  =
    (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
    (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign shifted  = acc_q >>> SHIFT;

  // Shift result saturated into the output range
  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > ACC_MAX) begin
      sat = OUT_MAX;
    end else if (shifted < ACC_MIN) begin
      sat = OUT_MIN;
    end
  end

  // Activation select; the reserved code acts as identity
  always_comb begin
    act_res = sat;
    case (mode_q)
      2'b01: begin
        if (shifted < 0) begin
          act_res = '0;
        end
      end
      2'b10: begin
        act_res = (shifted > 0) ? OUT_MAX : '0;
      end
      default: begin
        act_res = sat;
      end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_signal) begin
          x_d     = inputs;
          w_d     = weights;
          mode_d  = act_mode;
          acc_d   = bias;
          idx_d   = '0;
          ovf_d   = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        if (add_ovf) begin
          ovf_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ACT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ACT: begin
        out_d   = act_res;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      w_q     <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out          = out_q;
  assign ready_signal = rdy_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_neuron_serial_mac.sv
// Bench for neuron_serial_mac: three configurations driven in
// lockstep, results checked against a queued reference model.
module tb_neuron_serial_mac;

  localparam int N  = 8;
  localparam int DW = 8;

  typedef struct {
    logic [7:0] o;
    logic       v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N*DW-1:0] xin;
  logic [N*DW-1:0] win;
  logic [31:0]   bias;
  logic [1:0]    mode;

  logic [7:0] out0, out1, out2;
  logic       rdy0, rdy1, rdy2;
  logic       busy0, busy1, busy2;
  logic       ovf0, ovf1, ovf2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  neuron_serial_mac #(
    .DATA_W(8), .ACC_W(32), .INPUT_COUNT(N), .SHIFT(0)
  ) u0 (
    .clk(clk), .rst(rst), .start_signal(start),
    .inputs(xin), .weights(win), .bias(bias),
    .act_mode(mode), .out(out0), .ready_signal(rdy0),
    .busy(busy0), .overflow(ovf0)
  );

  neuron_serial_mac #(
    .DATA_W(8), .ACC_W(32), .INPUT_COUNT(N), .SHIFT(10)
  ) u1 (
    .clk(clk), .rst(rst), .start_signal(start),
    .inputs(xin), .weights(win), .bias(bias),
    .act_mode(mode), .out(out1), .ready_signal(rdy1),
    .busy(busy1), .overflow(ovf1)
  );

  neuron_serial_mac #(
    .DATA_W(8), .ACC_W(16), .INPUT_COUNT(N), .SHIFT(0)
  ) u2 (
    .clk(clk), .rst(rst), .start_signal(start),
    .inputs(xin), .weights(win), .bias(bias[15:0]),
    .act_mode(mode), .out(out2), .ready_signal(rdy2),
    .busy(busy2), .overflow(ovf2)
  );

  function automatic exp_t model(
    input int          acc_w,
    input int          sh,
    input logic [63:0] x,
    input logic [63:0] w,
    input longint      b,
    input logic [1:0]  m
  );
    exp_t   e;
    longint lim;
    longint acc;
    longint p;
    longint s;
    longint r;
    lim = longint'(1) <<< (acc_w - 1);
    acc = b;
    e.v = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = longint'($signed(x[i*8 +: 8])) *
          longint'($signed(w[i*8 +: 8]));
      acc = acc + p;
      if (acc >= lim) begin
        acc = acc - 2 * lim;
        e.v = 1'b1;
      end else if (acc < -lim) begin
        acc = acc + 2 * lim;
        e.v = 1'b1;
      end
    end
    s = acc >>> sh;
    case (m)
      2'b01:   r = (s < 0) ? 0 : ((s > 127) ? 127 : s);
      2'b10:   r = (s > 0) ? 127 : 0;
      default: r = (s > 127) ? 127 : ((s < -128) ? -128 : s);
    endcase
    e.o = r[7:0];
    return e;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string       tag,
    input logic [63:0] x,
    input logic [63:0] w,
    input longint      b,
    input logic [1:0]  m,
    input bit          glitch
  );
    int   cnt;
    exp_t e;
    @(negedge clk);
    xin   = x;
    win   = w;
    bias  = 32'(b);
    mode  = m;
    start = 1'b1;
    q0.push_back(model(32, 0, x, w, b, m));
    q1.push_back(model(32, 10, x, w, b, m));
    q2.push_back(model(16, 0, x, w, b, m));
    @(posedge clk);
    #1;
    start = 1'b0;
    xin   = {$urandom, $urandom};
    win   = {$urandom, $urandom};
    bias  = $urandom;
    mode  = 2'($urandom);
    chk({tag, " busy@start"}, busy0, 1);
    chk({tag, " rdy@start"}, rdy0, 0);
    cnt = 0;
    while (!rdy0 && cnt < 40) begin
      if (glitch && cnt == 2) start = 1'b1;
      @(posedge clk);
      cnt++;
      #1;
      start = 1'b0;
      if (!rdy0) chk({tag, " busy"}, busy0, 1);
    end
    chk({tag, " latency"}, cnt, 9);
    chk({tag, " busy@done"}, busy0, 0);
    chk({tag, " rdy1"}, rdy1, 1);
    chk({tag, " rdy2"}, rdy2, 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({tag, " out0"}, out0, e.o);
      chk({tag, " ovf0"}, ovf0, e.v);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({tag, " out1"}, out1, e.o);
      chk({tag, " ovf1"}, ovf1, e.v);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk({tag, " out2"}, out2, e.o);
      chk({tag, " ovf2"}, ovf2, e.v);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    xin   = '0;
    win   = '0;
    bias  = '0;
    mode  = 2'b00;
    #12;
    chk("rst out", out0, 0);
    chk("rst rdy", rdy0, 0);
    chk("rst busy", busy0, 0);
    chk("rst ovf", ovf0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("ones", {8{8'd1}}, {8{8'd2}}, 0, 2'b00, 0);
    chk("ones val", out0, 8'h10);
    run_op("sat", {8{8'd100}}, {8{8'd100}}, 0, 2'b00, 0);
    chk("sat val", out0, 8'd127);
    chk("shift val", out1, 8'd78);
    run_op("neg id", {8{8'hFD}}, {8{8'd5}}, 10, 2'b00, 0);
    chk("neg id val", out0, 8'h92);
    run_op("neg relu", {8{8'hFD}}, {8{8'd5}}, 10, 2'b01, 0);
    run_op("neg step", {8{8'hFD}}, {8{8'd5}}, 10, 2'b10, 0);
    run_op("pos step", {8{8'hFD}}, {8{8'd5}}, 200, 2'b10, 0);
    chk("pos step val", out0, 8'd127);
    run_op("ovf glitch", {8{8'h80}}, {8{8'h80}}, 0, 2'b00, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold rdy", rdy2, 1);
    chk("hold ovf", ovf2, 1);
    chk("hold out", out2, 0);
    chk("hold out0", out0, 127);
    run_op("ovf clear", {8{8'd1}}, {8{8'd1}}, 0, 2'b00, 0);
    chk("ovf clear val", ovf2, 0);

    @(negedge clk);
    xin   = {8{8'h80}};
    win   = {8{8'h80}};
    bias  = 0;
    mode  = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-rst ovf2", ovf2, 1);
    rst = 1'b1;
    #1;
    chk("mid-rst out0", out0, 0);
    chk("mid-rst out2", out2, 0);
    chk("mid-rst rdy", rdy0, 0);
    chk("mid-rst busy", busy0, 0);
    chk("mid-rst ovf2", ovf2, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst rdy", rdy0, 0);

    run_op("rsv mode", {$urandom, $urandom},
           {$urandom, $urandom}, 37, 2'b11, 0);
    for (int i = 0; i < 4; i++) begin
      run_op("rand", {$urandom, $urandom},
             {$urandom, $urandom},
             longint'($urandom_range(2000)) - 1000,
             2'($urandom_range(3)), 0);
    end

    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);
    chk("q2 empty", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
